// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the system-ID and timestamp words,
// compares them against build-time values and reports match/timeout status.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1381894597,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD_ID, S_RD_TS, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_read, r_addr, r_busy, r_done, r_match, r_timeout;
  logic [31:0]   r_id, r_ts;
  logic          w_stall_last;

  // The stall that would push a word past TIMEOUT_CYCLES read cycles aborts instead.
  assign w_stall_last = avm_waitrequest && (r_cnt == TO_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_read    <= 1'b0;
      r_addr    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_timeout <= 1'b0;
      r_id      <= '0;
      r_ts      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (AUTO_START || start) begin
            r_state <= S_RD_ID;
            r_read  <= 1'b1;
            r_addr  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_RD_ID: begin
          if (!avm_waitrequest) begin
            r_id    <= avm_readdata;
            r_state <= S_RD_TS;
            r_addr  <= 1'b1;
            r_cnt   <= '0;
          end else if (w_stall_last) begin
            r_state   <= S_DONE;
            r_read    <= 1'b0;
            r_addr    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_match   <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD_TS: begin
          if (!avm_waitrequest) begin
            r_ts      <= avm_readdata;
            r_state   <= S_DONE;
            r_read    <= 1'b0;
            r_addr    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_match   <= (r_id == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
            r_timeout <= 1'b0;
          end else if (w_stall_last) begin
            r_state   <= S_DONE;
            r_read    <= 1'b0;
            r_addr    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_match   <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state   <= S_RD_ID;
            r_read    <= 1'b1;
            r_addr    <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign avm_read    = r_read;
  assign avm_address = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign match       = r_match;
  assign timeout     = r_timeout;
  assign id_value    = r_id;
  assign ts_value    = r_ts;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master with a small configurable slave model.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_TS = 32'd1381894597;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, match, timeout;
  logic [31:0] id_value, ts_value;

  logic [31:0] id_data = 32'd0;
  logic [31:0] ts_data = EXP_TS;
  int          wait_n = 0;
  logic        stuck1 = 1'b0;
  int          wcnt;
  int          addr_bad = 0;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  sysid_check_master #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .match(match), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  // Slave: stalls the first wait_n cycles of every word, or forever on address 1.
  always @(posedge clock or negedge reset_n)
    if (!reset_n) wcnt <= 0;
    else if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;

  assign avm_waitrequest = avm_read && ((stuck1 && avm_address) || (wcnt < wait_n));
  assign avm_readdata    = avm_address ? ts_data : id_data;

  always @(negedge clock)
    if (!avm_read && avm_address) addr_bad <= addr_bad + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Optionally pulse start, then count negedges until done, tallying read cycles per address.
  task automatic run_check(input bit do_start, input bit busy_pulse,
                           output int cyc, output int n0, output int n1);
    bit seen;
    cyc = 0; n0 = 0; n1 = 0; seen = 0;
    if (do_start) start = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      start = 1'b0;
      cyc++;
      if (i == 0 && do_start) chk("done_clr", {31'd0, done}, 32'd0);
      if (busy_pulse && i == 1) start = 1'b1;
      if (avm_read) begin
        if (avm_address) n1++; else n0++;
      end
      if (done) seen = 1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  int cyc, n0, n1;

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_addr", {31'd0, avm_address}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {29'd0, done, match, timeout}, 32'd0);
    chk("rst_id", id_value, 32'd0);
    chk("rst_ts", ts_value, 32'd0);

    // Auto-start after reset release, zero-wait slave.
    reset_n = 1'b1;
    run_check(1'b0, 1'b0, cyc, n0, n1);
    chk("auto_cyc", cyc, 3);
    chk("auto_n0", n0, 1);
    chk("auto_n1", n1, 1);
    chk("auto_match", {31'd0, match}, 32'd1);
    chk("auto_to", {31'd0, timeout}, 32'd0);
    chk("auto_id", id_value, 32'd0);
    chk("auto_ts", ts_value, EXP_TS);
    chk("auto_busy", {31'd0, busy}, 32'd0);

    // Wrong ID word, rerun via start in DONE.
    id_data = 32'h1;
    run_check(1'b1, 1'b0, cyc, n0, n1);
    chk("badid_cyc", cyc, 3);
    chk("badid_match", {31'd0, match}, 32'd0);
    chk("badid_to", {31'd0, timeout}, 32'd0);
    chk("badid_id", id_value, 32'd1);

    // Three stall cycles per word, plus a start pulse while busy that must be ignored.
    id_data = 32'd0;
    wait_n = 3;
    run_check(1'b1, 1'b1, cyc, n0, n1);
    chk("wait_cyc", cyc, 9);
    chk("wait_n0", n0, 4);
    chk("wait_n1", n1, 4);
    chk("wait_match", {31'd0, match}, 32'd1);
    chk("wait_id", id_value, 32'd0);
    repeat (3) @(negedge clock);
    chk("wait_hold", {30'd0, done, busy}, 32'd2);

    // Stuck waitrequest on address 1 times out after 4 read cycles.
    wait_n = 0;
    stuck1 = 1'b1;
    ts_data = 32'hDEADBEEF;
    run_check(1'b1, 1'b0, cyc, n0, n1);
    chk("to_cyc", cyc, 6);
    chk("to_n0", n0, 1);
    chk("to_n1", n1, 4);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    chk("to_match", {31'd0, match}, 32'd0);
    chk("to_ts_kept", ts_value, EXP_TS);
    chk("to_read_low", {31'd0, avm_read}, 32'd0);

    // Reset mid-RD_TS: outputs clear asynchronously, then auto-start reruns.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("mid_in_ts", {30'd0, avm_read, avm_address}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_read", {31'd0, avm_read}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_ts", ts_value, 32'd0);
    stuck1 = 1'b0;
    ts_data = EXP_TS;
    @(negedge clock);
    reset_n = 1'b1;
    run_check(1'b0, 1'b0, cyc, n0, n1);
    chk("rerun_cyc", cyc, 3);
    chk("rerun_match", {31'd0, match}, 32'd1);
    chk("rerun_ts", ts_value, EXP_TS);

    chk("addr_idle_zero", addr_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
